// File: rtl/jrb8_mem_if.sv
// jrb8 external memory bus interface: multiplexed high/low address,
// then a timed read or write strobe. Optional macro: JRB8_MEMIF_ADDR_CACHE_EN.
module jrb8_mem_if #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        busy,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        ale_hi,
    output logic        ale_lo,
    output logic        rd_n,
    output logic        wr_n
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_HI = 3'd1;
    localparam logic [2:0] ADDR_LO = 3'd2;
    localparam logic [2:0] ACCESS  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        hit;

`ifdef JRB8_MEMIF_ADDR_CACHE_EN
    logic       hi_valid;
    logic [7:0] hi_last;

    assign hit = hi_valid && (addr[15:8] == hi_last);

    // Remember the high byte each time an ADDR_HI phase is issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_valid <= 1'b0;
            hi_last  <= 8'h00;
        end else if (state == IDLE && req && !hit) begin
            hi_valid <= 1'b1;
            hi_last  <= addr[15:8];
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Transaction FSM; every pad and core output is a register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata   <= 8'h00;
            done    <= 1'b0;
            busy    <= 1'b0;
            bus_out <= 8'h00;
            bus_oe  <= 8'h00;
            ale_hi  <= 1'b0;
            ale_lo  <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        bus_oe  <= 8'hFF;
                        if (hit) begin
                            state   <= ADDR_LO;
                            bus_out <= addr[7:0];
                            ale_lo  <= 1'b1;
                        end else begin
                            state   <= ADDR_HI;
                            bus_out <= addr[15:8];
                            ale_hi  <= 1'b1;
                        end
                    end
                end
                ADDR_HI: begin
                    state   <= ADDR_LO;
                    ale_hi  <= 1'b0;
                    ale_lo  <= 1'b1;
                    bus_out <= addr_q[7:0];
                end
                ADDR_LO: begin
                    state  <= ACCESS;
                    ale_lo <= 1'b0;
                    cnt    <= CNT_LOAD;
                    if (we_q) begin
                        bus_out <= wdata_q;
                        bus_oe  <= 8'hFF;
                        wr_n    <= 1'b0;
                    end else begin
                        bus_oe <= 8'h00;
                        rd_n   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        bus_oe <= 8'h00;
                        if (!we_q) begin
                            rdata <= bus_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    bus_oe <= 8'h00;
                    ale_hi <= 1'b0;
                    ale_lo <= 1'b0;
                    rd_n   <= 1'b1;
                    wr_n   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jrb8_mem_if.sv
// Bench for jrb8_mem_if: two instances (WAIT_CYCLES 2 and 3) share
// stimulus; per-cycle phase model plus read-data scoreboard.
module tb_jrb8_mem_if;

`ifdef JRB8_MEMIF_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  bus_in;

    logic [1:0][7:0] rdata_w;
    logic [1:0]      done_w;
    logic [1:0]      busy_w;
    logic [1:0][7:0] out_w;
    logic [1:0][7:0] oe_w;
    logic [1:0]      ale_hi_w;
    logic [1:0]      ale_lo_w;
    logic [1:0]      rd_n_w;
    logic [1:0]      wr_n_w;

    int nchk  = 0;
    int npass = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    bit         hi_valid = 1'b0;
    logic [7:0] hi_last  = 8'h00;

    always #5 clk = ~clk;

    jrb8_mem_if #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata_w[0]),
        .done(done_w[0]), .busy(busy_w[0]), .bus_in(bus_in),
        .bus_out(out_w[0]), .bus_oe(oe_w[0]),
        .ale_hi(ale_hi_w[0]), .ale_lo(ale_lo_w[0]),
        .rd_n(rd_n_w[0]), .wr_n(wr_n_w[0])
    );

    jrb8_mem_if #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata_w[1]),
        .done(done_w[1]), .busy(busy_w[1]), .bus_in(bus_in),
        .bus_out(out_w[1]), .bus_oe(oe_w[1]),
        .ale_hi(ale_hi_w[1]), .ale_lo(ale_lo_w[1]),
        .rd_n(rd_n_w[1]), .wr_n(wr_n_w[1])
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  bval;
        logic [7:0]  exp_rdata;
    } vec_t;

    function automatic int wv(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {done,busy,oe,bus_out,ale_hi,ale_lo,rd_n,wr_n}
    function automatic logic [21:0] act_vec(input int i);
        return {done_w[i], busy_w[i], oe_w[i], out_w[i],
                ale_hi_w[i], ale_lo_w[i], rd_n_w[i], wr_n_w[i]};
    endfunction

    function automatic logic [21:0] exp_vec(input int p, input int w,
        input logic wr, input logic [15:0] a, input logic [7:0] wd);
        logic [21:0] v;
        v = {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        if (p == 0) begin
            v[20] = 1'b1; v[19:12] = 8'hFF; v[11:4] = a[15:8]; v[3] = 1'b1;
        end else if (p == 1) begin
            v[20] = 1'b1; v[19:12] = 8'hFF; v[11:4] = a[7:0]; v[2] = 1'b1;
        end else if (p >= 2 && p <= w + 1) begin
            v[20] = 1'b1;
            if (wr) begin
                v[19:12] = 8'hFF; v[11:4] = wd; v[0] = 1'b0;
            end else begin
                v[1] = 1'b0;
            end
        end else if (p == w + 2) begin
            v[21] = 1'b1; v[20] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [21:0] mask_of(input logic [21:0] e);
        return (e[19:12] == 8'h00) ? 22'h3FF00F : 22'h3FFFFF;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        hi_valid = 1'b0;
    endtask

    task automatic pop_check(input int i);
        logic [7:0] e;
        if (i == 0) begin
            if (sb0.size() == 0) begin
                chk("spurious_done_w2", 32'd1, 32'd0);
                return;
            end
            e = sb0.pop_front();
        end else begin
            if (sb1.size() == 0) begin
                chk("spurious_done_w3", 32'd1, 32'd0);
                return;
            end
            e = sb1.pop_front();
        end
        chk($sformatf("rdata_w%0d", wv(i)), 32'(rdata_w[i]), 32'(e));
    endtask

    task automatic run_txn(input logic wr, input logic [15:0] a,
        input logic [7:0] wd, input logic [7:0] bv, input logic [7:0] er);
        logic h;
        logic [21:0] e;
        logic [21:0] m;
        h = CACHE && hi_valid && (a[15:8] == hi_last);
        if (!h) begin
            hi_valid = 1'b1;
            hi_last  = a[15:8];
        end
        sb0.push_back(er);
        sb1.push_back(er);
        @(negedge clk);
        req = 1'b1; we = wr; addr = a; wdata = wd; bus_in = bv;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~wr; addr = ~a; wdata = ~wd;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                e = exp_vec(k + int'(h), wv(i), wr, a, wd);
                m = mask_of(e);
                chk($sformatf("cyc_w%0d_a%h_k%0d", wv(i), a, k),
                    32'(act_vec(i) & m), 32'(e & m));
                if (done_w[i]) pop_check(i);
            end
        end
        chk("sb_left_w2", 32'(sb0.size()), 32'd0);
        chk("sb_left_w3", 32'(sb1.size()), 32'd0);
        sb0.delete();
        sb1.delete();
    endtask

    vec_t tbl[6];
    int   dn_got[2][$];
    int   dn_exp[2][$];

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0;
        addr = 16'h0000; wdata = 8'h00; bus_in = 8'h00;

        tbl[0] = '{1'b0, 16'h12A5, 8'h00, 8'h3C, 8'h3C};
        tbl[1] = '{1'b1, 16'h00FF, 8'h81, 8'h55, 8'h3C};
        tbl[2] = '{1'b0, 16'hFFFF, 8'h00, 8'hA7, 8'hA7};
        tbl[3] = '{1'b0, 16'h0000, 8'h00, 8'h01, 8'h01};
        tbl[4] = '{1'b1, 16'h1234, 8'hFE, 8'h66, 8'h01};
        tbl[5] = '{1'b0, 16'h12FE, 8'h00, 8'h00, 8'h00};

        // Reset then idle
        do_reset(2);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle_w%0d_c%0d", wv(i), c),
                    32'(act_vec(i)),
                    32'(exp_vec(99, wv(i), 1'b0, 16'h0, 8'h0)));
                chk($sformatf("idle_rdata_w%0d", wv(i)),
                    32'(rdata_w[i]), 32'h0);
            end
        end

        for (int t = 0; t < 6; t++)
            run_txn(tbl[t].we, tbl[t].addr, tbl[t].wdata,
                    tbl[t].bval, tbl[t].exp_rdata);

        // Cache sequence, then reset invalidates the cached high byte
        do_reset(1);
        run_txn(1'b0, 16'h4000, 8'h00, 8'h11, 8'h11);
        run_txn(1'b0, 16'h4001, 8'h00, 8'h22, 8'h22);
        do_reset(1);
        #1;
        chk("rdata_cleared_w2", 32'(rdata_w[0]), 32'h0);
        chk("rdata_cleared_w3", 32'(rdata_w[1]), 32'h0);
        run_txn(1'b0, 16'h4002, 8'h00, 8'h33, 8'h33);

        // req held high: back-to-back transactions, single done each
        do_reset(1);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h5A5A; bus_in = 8'h77;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (done_w[i]) dn_got[i].push_back(k);
        end
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int e0;
            int d;
            int h;
            e0 = 0;
            h  = 0;
            forever begin
                d = e0 + wv(i) + 2 - h;
                if (d >= 40) break;
                dn_exp[i].push_back(d);
                e0 = d + 2;
                h  = int'(CACHE);
            end
            chk($sformatf("held_cnt_w%0d", wv(i)),
                32'(dn_got[i].size()), 32'(dn_exp[i].size()));
            for (int j = 0; j < dn_exp[i].size(); j++)
                if (j < dn_got[i].size())
                    chk($sformatf("held_dn_w%0d_%0d", wv(i), j),
                        32'(dn_got[i][j]), 32'(dn_exp[i][j]));
        end
        repeat (12) @(posedge clk);

        // Reset during ACCESS abandons the transaction
        do_reset(1);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h1357; bus_in = 8'h9A;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_rd_w2", 32'(rd_n_w[0]), 32'd0);
        chk("abort_pre_rd_w3", 32'(rd_n_w[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort_vec_w%0d", wv(i)),
                32'(act_vec(i) & 22'h3FF00F),
                32'(exp_vec(99, wv(i), 1'b0, 16'h0, 8'h0)));
            chk($sformatf("abort_rdata_w%0d", wv(i)),
                32'(rdata_w[i]), 32'h0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        hi_valid = 1'b0;
        begin
            int nd;
            nd = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                nd += int'(done_w[0]) + int'(done_w[1]);
            end
            chk("abort_no_done", 32'(nd), 32'd0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
